pm_io_sequencer: RTL and testbench

//  Sequences the switch/LED handshake for the picoMIPS core. Synchronises and debounces
//  the SW8 strobe, then captures x1 and y1 from SW[7:0] on successive strobe presses.

---
 rtl/pm_io_pkg.sv | 18 +
 rtl/sw_debounce.sv | 50 +++++
 rtl/pm_io_sequencer.sv | 104 ++++++++++
 tb/tb_pm_io_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_io_pkg.sv
// Shared types and constants for the picoMIPS switch/LED I/O sequencer.
package pm_io_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    // REL_N has no code of its own: it is SHOW_Y with the debounced strobe held high.
    typedef enum logic [2:0] {
        WAIT_X = 3'd0,
        REL_X  = 3'd1,
        WAIT_Y = 3'd2,
        REL_Y  = 3'd3,
        BUSY   = 3'd4,
        SHOW_X = 3'd5,
        REL_S  = 3'd6,
        SHOW_Y = 3'd7
    } seq_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Synchronises an asynchronous, bouncy switch and emits a debounced level plus
// single-cycle press/release strobes in the cycle the level changes.
module sw_debounce
    import pm_io_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic fastclk,
    input  logic nReset,
    input  logic raw,
    output logic level,
    output logic press_c,
    output logic rel_c
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced, differ, flip;

    assign synced = sync_q[SYNC_STAGES-1];

    // Count consecutive samples that disagree with the level; any agreeing sample restarts.
    always_comb begin
        differ  = (synced != level_q);
        flip    = differ && (cnt_q == CNT_LAST);
        cnt_d   = (differ && !flip) ? cnt_q + CW'(1) : '0;
        level_d = flip ? synced : level_q;
        press_c = flip && synced;
        rel_c   = flip && !synced;
    end

    always_ff @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/pm_io_sequencer.sv
// Switch/LED handshake for the picoMIPS core: captures x1/y1 on strobe presses,
// starts the core, then shows x2 and y2 on LED on successive presses.
module pm_io_sequencer
    import pm_io_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic         fastclk,
    input  logic         nReset,
    input  logic [W-1:0] sw_data,
    input  logic         sw_strobe,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic         start,
    input  logic         done,
    input  logic [W-1:0] res_x,
    input  logic [W-1:0] res_y,
    output logic [W-1:0] LED,
    output logic [2:0]   phase
);

    seq_state_t   state_q, state_d;
    logic [W-1:0] x_q, x_d, y_q, y_d;
    logic [W-1:0] led_q, led_d, ry_q, ry_d;
    logic         start_q, start_d;
    logic         strobe_level, press_c, rel_c;

    sw_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .fastclk(fastclk),
        .nReset (nReset),
        .raw    (sw_strobe),
        .level  (strobe_level),
        .press_c(press_c),
        .rel_c  (rel_c)
    );

    // Next state; BUSY only reacts to done, so a coincident press is dropped.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        led_d   = led_q;
        ry_d    = ry_q;
        start_d = 1'b0;
        case (state_q)
            WAIT_X: if (press_c) begin
                x_d     = sw_data;
                state_d = REL_X;
            end
            REL_X:  if (rel_c) state_d = WAIT_Y;
            WAIT_Y: if (press_c) begin
                y_d     = sw_data;
                state_d = REL_Y;
            end
            REL_Y:  if (rel_c) begin
                start_d = 1'b1;
                state_d = BUSY;
            end
            BUSY:   if (done) begin
                ry_d    = res_y;
                led_d   = res_x;
                state_d = SHOW_X;
            end
            SHOW_X: if (press_c) begin
                led_d   = ry_q;
                state_d = REL_S;
            end
            REL_S:  if (rel_c) state_d = SHOW_Y;
            SHOW_Y: if (rel_c && strobe_level) begin
                led_d   = '0;
                state_d = WAIT_X;
            end
            default: state_d = WAIT_X;
        endcase
    end

    always_ff @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            state_q <= WAIT_X;
            x_q     <= '0;
            y_q     <= '0;
            led_q   <= '0;
            ry_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            led_q   <= led_d;
            ry_q    <= ry_d;
            start_q <= start_d;
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign start = start_q;
    assign LED   = led_q;
    assign phase = 3'(state_q);

endmodule

// File: tb/tb_pm_io_sequencer.sv
// Directed/randomised bench for pm_io_sequencer against a step-counting reference model.
module tb_pm_io_sequencer;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = DEB + 4;

    logic       fastclk, nReset, sw_strobe, done, start;
    logic [7:0] sw_data, res_x, res_y, x_out, y_out, LED;
    logic [2:0] phase;

    int n_checks = 0;
    int n_err    = 0;

    pm_io_sequencer #(.W(8), .DEB_CYCLES(DEB)) dut (
        .fastclk  (fastclk),
        .nReset   (nReset),
        .sw_data  (sw_data),
        .sw_strobe(sw_strobe),
        .x_out    (x_out),
        .y_out    (y_out),
        .start    (start),
        .done     (done),
        .res_x    (res_x),
        .res_y    (res_y),
        .LED      (LED),
        .phase    (phase)
    );

    initial begin
        fastclk = 1'b0;
        forever #5 fastclk = ~fastclk;
    end

    // Reference: two-sample delay, run-length debounce, then a 9-step handshake (8 = REL_N).
    logic [1:0]  m_sync;
    logic        m_level, m_pr, m_rl, m_start;
    int unsigned m_run, m_run_n;
    int          m_step;
    logic [7:0]  m_x, m_y, m_led, m_r2;

    always_comb begin
        m_run_n = (m_sync[1] != m_level) ? m_run + 1 : 0;
        m_pr    = (m_run_n == DEB) && m_sync[1];
        m_rl    = (m_run_n == DEB) && !m_sync[1];
    end

    always @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            m_sync <= '0; m_level <= 1'b0; m_run <= 0; m_step <= 0;
            m_x <= '0; m_y <= '0; m_led <= '0; m_r2 <= '0; m_start <= 1'b0;
        end else begin
            m_sync  <= {m_sync[0], sw_strobe};
            m_run   <= (m_run_n == DEB) ? 0 : m_run_n;
            if (m_run_n == DEB) m_level <= m_sync[1];
            m_start <= 1'b0;
            case (m_step)
                0: if (m_pr) begin m_x <= sw_data; m_step <= 1; end
                1: if (m_rl) m_step <= 2;
                2: if (m_pr) begin m_y <= sw_data; m_step <= 3; end
                3: if (m_rl) begin m_start <= 1'b1; m_step <= 4; end
                4: if (done) begin m_r2 <= res_y; m_led <= res_x; m_step <= 5; end
                5: if (m_pr) begin m_led <= m_r2; m_step <= 6; end
                6: if (m_rl) m_step <= 7;
                7: if (m_pr) m_step <= 8;
                8: if (m_rl) begin m_led <= '0; m_step <= 0; end
                default: m_step <= 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("x_out", 32'(x_out), 32'(m_x));
        chk("y_out", 32'(y_out), 32'(m_y));
        chk("start", 32'(start), 32'(m_start));
        chk("LED",   32'(LED),   32'(m_led));
        chk("phase", 32'(phase), (m_step == 8) ? 32'd7 : 32'(m_step));
    endtask

    task automatic tick();
        @(posedge fastclk);
        @(negedge fastclk);
        check_all();
    endtask

    task automatic pulse();
        sw_strobe = 1'b1;
        repeat (HOLD) tick();
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic run_sequence(input logic [7:0] xv, input logic [7:0] yv,
                                input logic [7:0] rx, input logic [7:0] ry);
        int first;
        int width;
        sw_data = xv;
        pulse();
        sw_data   = yv;
        sw_strobe = 1'b1;
        repeat (HOLD) tick();
        sw_strobe = 1'b0;
        sw_data   = 8'($urandom);
        first = 0;
        width = 0;
        for (int k = 1; k <= int'(HOLD) + 4; k++) begin
            tick();
            if (start === 1'b1) begin
                width++;
                if (first == 0) first = k;
            end
        end
        chk("start_latency", 32'(first), 32'(2 + DEB));
        chk("start_width", 32'(width), 32'd1);
        chk("x_captured", 32'(x_out), 32'(xv));
        chk("y_captured", 32'(y_out), 32'(yv));
        chk("busy_phase", 32'(phase), 32'd4);
        chk("busy_led", 32'(LED), 32'd0);
        res_x = rx;
        res_y = ry;
        done  = 1'b1;
        tick();
        done  = 1'b0;
        res_x = 8'($urandom);
        res_y = 8'($urandom);
        chk("led_x2", 32'(LED), 32'(rx));
        chk("showx_phase", 32'(phase), 32'd5);
        pulse();
        chk("led_y2", 32'(LED), 32'(ry));
        chk("showy_phase", 32'(phase), 32'd7);
        sw_strobe = 1'b1;
        repeat (HOLD) tick();
        chk("reln_led", 32'(LED), 32'(ry));
        chk("reln_phase", 32'(phase), 32'd7);
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        chk("wrap_led", 32'(LED), 32'd0);
        chk("wrap_phase", 32'(phase), 32'd0);
    endtask

    initial begin
        logic [7:0] bd, rx, ry;
        nReset = 1'b0; sw_strobe = 1'b0; sw_data = '0;
        done = 1'b0; res_x = '0; res_y = '0;

        // Reset values
        #30;
        check_all();
        chk("rst_led", 32'(LED), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        @(negedge fastclk);
        nReset = 1'b1;
        tick();

        // Directed operand/result pair
        run_sequence(8'hFF, 8'h01, 8'h12, 8'h34);

        // Bouncy strobe: one press only, x captured once
        bd = 8'($urandom);
        sw_data = bd;
        sw_strobe = 1'b1; tick();
        sw_strobe = 1'b0; tick();
        sw_strobe = 1'b1;
        repeat (HOLD) tick();
        chk("bounce_phase", 32'(phase), 32'd1);
        chk("bounce_x", 32'(x_out), 32'(bd));
        sw_data = ~bd;
        repeat (HOLD) tick();
        chk("bounce_x_hold", 32'(x_out), 32'(bd));
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        chk("bounce_release", 32'(phase), 32'd2);
        sw_data = 8'($urandom);
        pulse();
        chk("bounce_busy", 32'(phase), 32'd4);

        // Strobe activity in BUSY without done is ignored
        pulse();
        chk("busy_hold_phase", 32'(phase), 32'd4);
        chk("busy_hold_led", 32'(LED), 32'd0);

        // done coincident with a press: done wins
        rx = 8'($urandom);
        ry = 8'($urandom);
        sw_strobe = 1'b1;
        repeat (DEB + 1) tick();
        res_x = rx; res_y = ry; done = 1'b1;
        tick();
        done = 1'b0;
        chk("done_press_phase", 32'(phase), 32'd5);
        chk("done_press_led", 32'(LED), 32'(rx));
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        chk("showx_no_release", 32'(phase), 32'd5);

        // Asynchronous reset in SHOW_X
        #2 nReset = 1'b0;
        #1;
        chk("async_led", 32'(LED), 32'd0);
        chk("async_phase", 32'(phase), 32'd0);
        chk("async_start", 32'(start), 32'd0);
        chk("async_x", 32'(x_out), 32'd0);
        @(negedge fastclk);
        check_all();
        nReset = 1'b1;
        tick();

        // Full sequence repeats after reset with random data
        for (int i = 0; i < 3; i++)
            run_sequence(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
